// File: rtl/ro_sched_pkg.sv
// Readout scheduler shared types: FSM state enum, default sizing, width helper.
// Imported by ro_rr_pick and ro_bus_scheduler.
package ro_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } st_e;

  localparam int N_CH_DEF = 8;
  localparam int HOLD_DEF = 2;
  localparam int GAP_DEF  = 1;

  function automatic int wof(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_rr_pick.sv
// Combinational channel picker: round-robin from last+1 (default) or
// lowest-index fixed priority when RO_FIXED_PRI_EN is defined.
// Ports: pend/last in; found/idx out.
module ro_rr_pick
  import ro_sched_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int IW   = wof(N_CH)
) (
  input  logic [N_CH-1:0] pend,
  input  logic [IW-1:0]   last,
  output logic            found,
  output logic [IW-1:0]   idx
);

`ifdef RO_FIXED_PRI_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end
`else
  // Walk from farthest to nearest so the nearest
  // candidate after last is the final assignment.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      int c;
      c = (int'(last) + k) % N_CH;
      if (pend[c]) begin
        found = 1'b1;
        idx   = IW'(c);
      end
    end
  end
`endif

endmodule

// File: rtl/ro_bus_scheduler.sv
// Request-driven readout bus arbiter: one-hot tristate enables, hold
// window, dead gap. Ports: clk, rstb, en, req, ovf_clr in; ctrl, ch_id,
// strobe, pend, ovf, busy out. Option macro: RO_FIXED_PRI_EN.
module ro_bus_scheduler
  import ro_sched_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int HOLD_CYC = HOLD_DEF,
  parameter int GAP_CYC  = GAP_DEF
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     en,
  input  logic [N_CH-1:0]          req,
  input  logic                     ovf_clr,
  output logic [N_CH-1:0]          ctrl,
  output logic [$clog2(N_CH)-1:0]  ch_id,
  output logic                     strobe,
  output logic [N_CH-1:0]          pend,
  output logic [N_CH-1:0]          ovf,
  output logic                     busy
);

  localparam int IW = $clog2(N_CH);
  localparam int CW = wof(imax(HOLD_CYC, GAP_CYC) + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);

  st_e             state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   last;
  logic            found;
  logic [IW-1:0]   pick;
  logic            go;
  logic [N_CH-1:0] gnt;
  logic [N_CH-1:0] pend_n;
  logic [N_CH-1:0] ovf_n;

  ro_rr_pick #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_pick (
    .pend  (pend),
    .last  (last),
    .found (found),
    .idx   (pick)
  );

  assign go = en && found &&
              (state == IDLE ||
               (state == GAP && cnt == '0));

  always_comb begin
    gnt = '0;
    if (go) gnt[pick] = 1'b1;
  end

  // A request landing on its own grant edge stays pending;
  // ovf_clr loses to a coincident overflow.
  always_comb begin
    pend_n = (pend & ~gnt) | req;
    ovf_n  = ovf_clr ? '0 : ovf;
    ovf_n  = ovf_n | (req & pend & ~gnt);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= IW'(N_CH - 1);
      ctrl   <= '0;
      ch_id  <= '0;
      strobe <= 1'b0;
      pend   <= '0;
      ovf    <= '0;
      busy   <= 1'b0;
    end else begin
      pend <= pend_n;
      ovf  <= ovf_n;
      if (go) begin
        state  <= DRIVE;
        cnt    <= HOLD_LD;
        ctrl   <= gnt;
        ch_id  <= pick;
        last   <= pick;
        strobe <= (HOLD_CYC == 1);
        busy   <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          DRIVE: begin
            if (cnt != '0) begin
              cnt    <= cnt - 1'b1;
              strobe <= (cnt == CW'(1));
            end else begin
              state  <= GAP;
              cnt    <= GAP_LD;
              ctrl   <= '0;
              strobe <= 1'b0;
            end
          end
          GAP: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            ctrl  <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ro_bus_scheduler.md
# ro_bus_scheduler

Time-multiplexes the shared tristate readout bus among the cochlea filter channels. Each channel raises a one-cycle sample-ready request. The scheduler grants the bus to exactly one channel at a time, holds its tristate enable for a fixed window, and then inserts a dead gap before the next grant. It replaces free-running divided-clock enable decoding with a request-driven, contention-free arbitration stage that sits between the channel clock dividers and the readout tristate buffers.

## Interface
Parameters:
- N_CH, 8: number of channels/tristate drivers (2..16).
- HOLD_CYC, 2: cycles a grant keeps its enable asserted (>=1).
- GAP_CYC, 1: dead cycles with all enables low between grants (>=1).

Ports:
- clk  in  1  single clock; all logic is posedge.
- rstb  in  1  reset, asynchronous, active-low.
- en  in  1  scheduler enable; low blocks new grants only.
- req  in  N_CH  one-cycle sample-ready pulse per channel.
- ovf_clr  in  1  clears all sticky overflow flags.
- ctrl  out  N_CH  registered one-hot (or zero) tristate enables.
- ch_id  out  $clog2(N_CH)  index of the granted channel; holds its last value otherwise.
- strobe  out  1  high on the last DRIVE cycle (bus capture point).
- pend  out  N_CH  pending-request vector.
- ovf  out  N_CH  sticky per-channel dropped-sample flag.
- busy  out  1  high whenever FSM is not IDLE.

## Operation
- Reset: ctrl=0, ch_id=0, strobe=0, pend=0, ovf=0, busy=0, state=IDLE, and the round-robin pointer last=N_CH-1, so channel 0 is the first candidate.
- Reset asserted mid-grant clears ctrl asynchronously, releasing the bus immediately.
- Pending:
  - pend[i] is set by req[i].
  - pend[i] is cleared on the edge that enters DRIVE for channel i.
  - If req[i] arrives on that same edge, pend[i] stays set and ovf[i] is not set.
- Overflow: req[i] while pend[i]=1 and channel i is not being granted sets ovf[i]. If ovf_clr coincides with a new overflow event, the set wins.
- FSM states are IDLE, DRIVE and GAP.
  - IDLE: if en and any pend bit is set, pick a channel and go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: ctrl has the chosen bit set and ch_id is valid. The state lasts HOLD_CYC cycles, and strobe is high in the last of them. It then goes to GAP.
  - GAP: ctrl=0 for GAP_CYC cycles. On the last GAP cycle:
    - if en and any pend bit is set, pick a channel and go straight to DRIVE;
    - otherwise go to IDLE.
- Selection is round-robin: search starts at last+1 and wraps at N_CH-1 back to 0. last updates to the granted index.
- en deasserted during DRIVE lets the current grant finish, including GAP. Requests continue to accumulate in pend.
- ctrl never has more than one bit set. Two successive grants are always separated by at least GAP_CYC all-zero cycles.
- Down-counter width is $clog2(max(HOLD_CYC,GAP_CYC)+1). The counter loads HOLD_CYC-1 or GAP_CYC-1 on state entry.

## Timing
- req[i] sampled at edge e0 makes pend[i] high after e0.
- From IDLE, the grant decision is made at e1. ctrl[i] is high from e1 through e1+HOLD_CYC.
- Request-to-enable latency is 2 edges.
- Back-to-back grant period is HOLD_CYC+GAP_CYC cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro RO_FIXED_PRI_EN.
  - Defined: fixed priority replaces round-robin. The lowest index wins (channel 0, the fastest clock), and the last pointer is unused.
  - Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

## Structure
- Package ro_sched_pkg holds:
  - the state enum (IDLE, DRIVE, GAP);
  - default constants for N_CH, HOLD_CYC and GAP_CYC;
  - a width helper function for ch_id and the counter.
- Sub-module ro_rr_pick: a combinational picker.
  - Inputs: pend and last.
  - Outputs: a found flag and the index.
  - Contains the RO_FIXED_PRI_EN switch.

## Test plan
- Reset, then a req[3] pulse:
  - ctrl=8'h08 for 2 cycles starting 2 edges later;
  - strobe is high in the second of those cycles and ch_id=3;
  - one gap cycle follows, then busy drops.
- req=8'hFF in one cycle: grants run in order 0..7, each 2 cycles high plus a 1-cycle gap. No overlap, and ctrl never has two bits set.
- Two consecutive req[5] pulses while a grant to channel 2 is active: ovf[5]=1 and pend[5] remains 1. An ovf_clr pulse afterwards returns ovf to 0.
- en=0 with req[1], req[6] pulsed: no grant and pend=8'h42. Raising en grants 1 then 6. With RO_FIXED_PRI_EN, a new req[0] arriving after 6's grant was issued waits and is served next.
- rstb asserted in the middle of DRIVE: ctrl drops to 0 without waiting for a clock edge. All outputs and pend reach their reset values, and the first grant after release goes to channel 0.
